id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding. Sits directly upstream of the ALU.
- Captures decoded operands and control from ID and resolves RAW hazards against the EX/MEM and MEM/WB results.
- Drives the ALU's a/b operands and 4-bit ALU control code, plus store data and writeback tags for later stages.
- Supports stall (hold) and flush (bubble). While stalled, it refreshes held operands so forwarded data retiring from WB is not lost.

---
 rtl/id_ex_operand_stage_if.sv | 53 +++++
 rtl/id_ex_operand_stage.sv | 89 ++++++++
 tb/tb_id_ex_operand_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between ID, the EX/MEM and MEM/WB producers, and the ID/EX operand stage.
// The stage uses the slave view; the driving environment uses the master view.
interface id_ex_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [XLEN-1:0]   id_rs1_val;
    logic [XLEN-1:0]   id_rs2_val;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_pc;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_a_sel;
    logic              id_b_sel;
    logic [4:0]        id_rd;
    logic              id_reg_write;

    logic              exm_reg_write;
    logic [4:0]        exm_rd;
    logic [XLEN-1:0]   exm_result;
    logic              mwb_reg_write;
    logic [4:0]        mwb_rd;
    logic [XLEN-1:0]   mwb_result;

    logic              ex_valid;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic [XLEN-1:0]   ex_pc;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_pc,
               id_alu_ctrl, id_a_sel, id_b_sel, id_rd, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               mwb_reg_write, mwb_rd, mwb_result,
        output ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_pc
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_pc,
               id_alu_ctrl, id_a_sel, id_b_sel, id_rd, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               mwb_reg_write, mwb_rd, mwb_result,
        input  ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_pc
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Supports stall (hold, with forwarded-operand refresh) and flush (bubble).
module id_ex_operand_stage #(
    parameter int                XLEN     = 32,
    parameter int                CTRL_W   = 4,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic flush,
    id_ex_operand_stage_if.slave bus
);
    logic              valid_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [XLEN-1:0]   rs1_val_q;
    logic [XLEN-1:0]   rs2_val_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic              a_sel_q;
    logic              b_sel_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;

    logic [XLEN-1:0]   fwd1;
    logic [XLEN-1:0]   fwd2;

    // EX/MEM is the younger producer, so it takes precedence; x0 is never forwarded.
    always_comb begin
        fwd1 = rs1_val_q;
        if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == rs1_q))
            fwd1 = bus.exm_result;
        else if (bus.mwb_reg_write && (bus.mwb_rd != 5'd0) && (bus.mwb_rd == rs1_q))
            fwd1 = bus.mwb_result;
    end

    always_comb begin
        fwd2 = rs2_val_q;
        if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == rs2_q))
            fwd2 = bus.exm_result;
        else if (bus.mwb_reg_write && (bus.mwb_rd != 5'd0) && (bus.mwb_rd == rs2_q))
            fwd2 = bus.mwb_result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            alu_ctrl_q  <= NOP_CTRL;
            a_sel_q     <= 1'b0;
            b_sel_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (stall) begin
            // Capture forwarded data so a producer retiring during the stall is not lost.
            rs1_val_q <= fwd1;
            rs2_val_q <= fwd2;
        end else begin
            valid_q     <= bus.id_valid;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rs1_val_q   <= bus.id_rs1_val;
            rs2_val_q   <= bus.id_rs2_val;
            imm_q       <= bus.id_imm;
            pc_q        <= bus.id_pc;
            alu_ctrl_q  <= bus.id_alu_ctrl;
            a_sel_q     <= bus.id_a_sel;
            b_sel_q     <= bus.id_b_sel;
            rd_q        <= bus.id_rd;
            reg_write_q <= bus.id_reg_write;
        end
    end

    assign bus.alu_a         = a_sel_q ? pc_q : fwd1;
    assign bus.alu_b         = b_sel_q ? imm_q : fwd2;
    assign bus.ex_store_data = fwd2;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_reg_write  = reg_write_q & valid_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_pc         = pc_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, hand sequences for stall/flush,
// and randomized traffic checked against a behavioural pipeline model.
module tb_id_ex_operand_stage;
    localparam int XLEN = 32;
    localparam int CTRL_W = 4;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    int pass_cnt = 0;
    int total_cnt = 0;

    id_ex_operand_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NOP_CTRL(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] v1, v2, imm, pc;
        logic        a_sel, b_sel;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, valid;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic [31:0] exp_a, exp_b, exp_sd;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[6];

    // Architectural view of the instruction sitting in EX.
    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm, pc;
        logic        a_sel, b_sel, rw;
        logic [3:0]  ctrl;
    } instr_t;

    instr_t ex_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic a_sel, input logic b_sel,
                          input logic [3:0] ctrl, input logic [4:0] rd, input logic rw);
        bus.id_valid = valid;      bus.id_rs1 = rs1;       bus.id_rs2 = rs2;
        bus.id_rs1_val = v1;       bus.id_rs2_val = v2;    bus.id_imm = imm;
        bus.id_pc = pc;            bus.id_a_sel = a_sel;   bus.id_b_sel = b_sel;
        bus.id_alu_ctrl = ctrl;    bus.id_rd = rd;         bus.id_reg_write = rw;
    endtask

    task automatic set_prod(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                            input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exm_reg_write = ew; bus.exm_rd = erd; bus.exm_result = eres;
        bus.mwb_reg_write = mw; bus.mwb_rd = mrd; bus.mwb_result = mres;
    endtask

    // Value an EX operand read of register r sees, given its stored copy v.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] v);
        if (r == 5'd0) return v;
        if (bus.exm_reg_write && bus.exm_rd == r) return bus.exm_result;
        if (bus.mwb_reg_write && bus.mwb_rd == r) return bus.mwb_result;
        return v;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] o1, o2;
        o1 = operand(ex_instr.rs1, ex_instr.v1);
        o2 = operand(ex_instr.rs2, ex_instr.v2);
        chk({tag, " ex_valid"}, bus.ex_valid, ex_instr.valid);
        chk({tag, " ex_reg_write"}, bus.ex_reg_write, ex_instr.valid && ex_instr.rw);
        chk({tag, " alu_ctrl"}, bus.alu_ctrl, ex_instr.ctrl);
        chk({tag, " ex_rd"}, bus.ex_rd, ex_instr.rd);
        chk({tag, " ex_pc"}, bus.ex_pc, ex_instr.pc);
        chk({tag, " alu_a"}, bus.alu_a, ex_instr.a_sel ? ex_instr.pc : o1);
        chk({tag, " alu_b"}, bus.alu_b, ex_instr.b_sel ? ex_instr.imm : o2);
        chk({tag, " store"}, bus.ex_store_data, o2);
    endtask

    // Next EX contents given the inputs present at the coming edge.
    function automatic instr_t next_instr(input instr_t cur);
        instr_t n;
        n = cur;
        if (!rst_n || flush) begin
            n = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0, v2: 32'd0,
                  imm: 32'd0, pc: 32'd0, a_sel: 1'b0, b_sel: 1'b0, rw: 1'b0, ctrl: 4'd0};
        end else if (stall) begin
            n.v1 = operand(cur.rs1, cur.v1);
            n.v2 = operand(cur.rs2, cur.v2);
        end else begin
            n = '{valid: bus.id_valid, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                  v1: bus.id_rs1_val, v2: bus.id_rs2_val, imm: bus.id_imm, pc: bus.id_pc,
                  a_sel: bus.id_a_sel, b_sel: bus.id_b_sel, rw: bus.id_reg_write,
                  ctrl: bus.id_alu_ctrl};
        end
        return n;
    endfunction

    task automatic randomize_inputs();
        logic [4:0] r1, r2;
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        set_id(1'($urandom), r1, r2, (r1 == 0) ? 32'd0 : $urandom, (r2 == 0) ? 32'd0 : $urandom,
               $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), 5'($urandom),
               1'($urandom));
        set_prod(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 9) == 0);
        rst_n = ($urandom_range(0, 29) != 0);
    endtask

    initial begin
        vecs[0] = '{rs1:1, rs2:2, v1:5, v2:7, imm:0, pc:32'h40, a_sel:0, b_sel:0, ctrl:0, rd:5,
                    rw:1, valid:1, ew:0, erd:0, eres:0, mw:0, mrd:0, mres:0,
                    exp_a:5, exp_b:7, exp_sd:7, exp_wr:1};
        vecs[1] = '{rs1:3, rs2:6, v1:1, v2:2, imm:0, pc:32'h44, a_sel:0, b_sel:0, ctrl:0, rd:9,
                    rw:1, valid:1, ew:1, erd:3, eres:32'hAAAA, mw:1, mrd:3, mres:32'hBBBB,
                    exp_a:32'hAAAA, exp_b:2, exp_sd:2, exp_wr:1};
        vecs[2] = '{rs1:3, rs2:6, v1:1, v2:2, imm:0, pc:32'h48, a_sel:0, b_sel:0, ctrl:0, rd:9,
                    rw:1, valid:1, ew:0, erd:3, eres:32'hAAAA, mw:1, mrd:3, mres:32'hBBBB,
                    exp_a:32'hBBBB, exp_b:2, exp_sd:2, exp_wr:1};
        vecs[3] = '{rs1:0, rs2:0, v1:0, v2:0, imm:0, pc:32'h4C, a_sel:0, b_sel:0, ctrl:2, rd:1,
                    rw:1, valid:1, ew:1, erd:0, eres:32'hFFFF_FFFF, mw:1, mrd:0, mres:32'h1234,
                    exp_a:0, exp_b:0, exp_sd:0, exp_wr:1};
        vecs[4] = '{rs1:1, rs2:4, v1:3, v2:1, imm:32'h10, pc:32'h100, a_sel:1, b_sel:1, ctrl:3,
                    rd:2, rw:1, valid:0, ew:0, erd:0, eres:0, mw:1, mrd:4, mres:9,
                    exp_a:32'h100, exp_b:32'h10, exp_sd:9, exp_wr:0};
        vecs[5] = '{rs1:7, rs2:8, v1:11, v2:12, imm:0, pc:32'h50, a_sel:0, b_sel:0, ctrl:1, rd:3,
                    rw:0, valid:1, ew:1, erd:8, eres:32'h55, mw:1, mrd:7, mres:32'h66,
                    exp_a:32'h66, exp_b:32'h55, exp_sd:32'h55, exp_wr:0};

        // Reset with random inputs, including stall and flush asserted.
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        randomize_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", bus.ex_valid, 1'b0);
        chk("reset ex_reg_write", bus.ex_reg_write, 1'b0);
        chk("reset alu_ctrl", bus.alu_ctrl, 4'd0);
        chk("reset alu_a", bus.alu_a, 32'd0);
        chk("reset alu_b", bus.alu_b, 32'd0);

        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        set_prod(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].v1, vecs[i].v2, vecs[i].imm,
                   vecs[i].pc, vecs[i].a_sel, vecs[i].b_sel, vecs[i].ctrl, vecs[i].rd, vecs[i].rw);
            set_prod(0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            set_prod(vecs[i].ew, vecs[i].erd, vecs[i].eres, vecs[i].mw, vecs[i].mrd, vecs[i].mres);
            #1;
            chk($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d alu_b", i), bus.alu_b, vecs[i].exp_b);
            chk($sformatf("vec%0d store", i), bus.ex_store_data, vecs[i].exp_sd);
            chk($sformatf("vec%0d ex_reg_write", i), bus.ex_reg_write, vecs[i].exp_wr);
            chk($sformatf("vec%0d ex_valid", i), bus.ex_valid, vecs[i].valid);
            chk($sformatf("vec%0d alu_ctrl", i), bus.alu_ctrl, vecs[i].ctrl);
        end

        // Stall refresh: MEM/WB result for rs2 must survive its own retirement.
        @(negedge clk);
        set_prod(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 4, 0, 1, 0, 32'h200, 0, 0, 4'd0, 6, 1);
        @(negedge clk);
        stall = 1'b1;
        set_id(1, 5, 9, 32'h33, 32'h77, 32'h99, 32'h300, 1, 1, 4'd7, 7, 0);
        set_prod(0, 0, 0, 1, 4, 9);
        #1;
        chk("stall fwd alu_b", bus.alu_b, 32'd9);
        @(negedge clk);
        set_prod(0, 0, 0, 0, 4, 32'hDEAD);
        #1;
        chk("stall held alu_b", bus.alu_b, 32'd9);
        chk("stall held store", bus.ex_store_data, 32'd9);
        chk("stall held pc", bus.ex_pc, 32'h200);
        @(negedge clk);
        chk("stall held2 alu_b", bus.alu_b, 32'd9);
        chk("stall held2 rd", bus.ex_rd, 5'd6);

        // Flush wins over stall.
        set_id(1, 1, 2, 3, 4, 0, 32'h400, 0, 0, 4'd5, 8, 1);
        stall = 1'b0;
        @(negedge clk);
        chk("pre-flush ex_reg_write", bus.ex_reg_write, 1'b1);
        stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush ex_valid", bus.ex_valid, 1'b0);
        chk("flush ex_reg_write", bus.ex_reg_write, 1'b0);
        chk("flush alu_ctrl", bus.alu_ctrl, 4'd0);
        stall = 1'b0; flush = 1'b0;
        set_id(1, 1, 4, 3, 1, 32'h10, 32'h500, 0, 1, 4'd2, 8, 1);
        set_prod(1, 4, 32'hCAFE, 0, 0, 0);
        @(negedge clk);
        chk("imm alu_b", bus.alu_b, 32'h10);
        chk("imm store fwd", bus.ex_store_data, 32'hCAFE);

        // Randomized traffic against the behavioural model.
        rst_n = 1'b0;
        ex_instr = next_instr(ex_instr);
        @(posedge clk);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            randomize_inputs();
            #1;
            check_model($sformatf("rnd%0d", n));
            ex_instr = next_instr(ex_instr);
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
